// File: rtl/fbwriter_nbuf.sv
// Framebuffer writer: pops rasteriser commands and issues single-beat PLB writes
// for pixels, buffer swaps, and clear sweeps across NUM_BUFS rotating buffers.
module fbwriter_nbuf #(
    parameter logic [31:0] FB_BASE_ADDR      = 32'h9000_0000,
    parameter logic [31:0] FB_CNTL_ADDR      = 32'h40A0_8000,
    parameter int unsigned NUM_BUFS          = 2,
    parameter int unsigned BUF_SHIFT         = 21,
    parameter int unsigned LINE_SHIFT        = 12,
    parameter int unsigned LINE_LEN          = 9,
    parameter int unsigned COL_LEN           = 10,
    parameter int unsigned H_RES             = 640,
    parameter int unsigned V_RES             = 480,
    parameter int unsigned MAX_RETRY         = 3,
    parameter int unsigned RAST_FBW_FIFO_LEN = 96
) (
    input  logic                           PLB_clk,
    input  logic                           Bus2IP_Reset,
    input  logic [0:RAST_FBW_FIFO_LEN-1]   fifo_data,
    input  logic                           fifo_empty,
    output logic                           fifo_rd_en,
    output logic                           IP2Bus_MstWr_Req,
    output logic                           IP2Bus_MstRd_Req,
    output logic [0:31]                    IP2Bus_Mst_Addr,
    output logic [0:3]                     IP2Bus_Mst_BE,
    output logic                           IP2Bus_Mst_Lock,
    output logic                           IP2Bus_Mst_Reset,
    output logic [0:31]                    IP2Bus_MstWr_d,
    input  logic                           Bus2IP_Mst_CmdAck,
    input  logic                           Bus2IP_Mst_Cmplt,
    input  logic                           Bus2IP_Mst_Error,
    input  logic                           Bus2IP_Mst_Cmd_Timeout,
    output logic                           busy,
    output logic                           clearing,
    output logic [1:0]                     front_buf,
    output logic                           err_flag,
    output logic [15:0]                    drop_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_DEC, S_PIX_REQ, S_CNTL_REQ, S_CLR_REQ, S_WAIT, S_DONE
    } state_t;

    typedef enum logic [1:0] {K_PIX, K_CNTL, K_CLR} kind_t;

    state_t              r_state, w_next;
    kind_t               r_kind;
    logic [31:0]         r_addr, r_data, r_clr_col;
    logic [1:0]          r_front, r_back, w_back_nx;
    logic                r_clr_pending, r_clearing, r_err;
    logic [LINE_LEN-1:0] r_line, w_line, w_line_nx;
    logic [COL_LEN-1:0]  r_col, w_col, w_col_nx;
    logic [7:0]          r_retry;
    logic [15:0]         r_drops;
    logic [3:0]          w_op;
    logic [31:0]         w_colour;
    logic                w_drop, w_in_req, w_fail, w_cmplt, w_retry, w_last, w_col_end;

    function automatic logic [31:0] addr_of(input logic [1:0] b,
                                            input logic [LINE_LEN-1:0] l,
                                            input logic [COL_LEN-1:0] c);
        return FB_BASE_ADDR + (32'(b) << BUF_SHIFT) + (32'(l) << LINE_SHIFT) + (32'(c) << 2);
    endfunction

    // An all-ones word is how the rasteriser signals end-of-frame.
    assign w_op      = (&fifo_data) ? 4'd1 : fifo_data[0:3];
    assign w_line    = fifo_data[16-LINE_LEN:15];
    assign w_col     = fifo_data[32-COL_LEN:31];
    assign w_colour  = fifo_data[32:63];
    assign w_drop    = (32'(w_line) >= V_RES) || (32'(w_col) >= H_RES);

    assign w_in_req  = (r_state == S_PIX_REQ) || (r_state == S_CNTL_REQ) || (r_state == S_CLR_REQ);
    assign w_fail    = Bus2IP_Mst_Error | Bus2IP_Mst_Cmd_Timeout;
    // Ack and complete in the same cycle is a finished transfer, not just an ack.
    assign w_cmplt   = Bus2IP_Mst_Cmplt && ((r_state == S_WAIT) || (w_in_req && Bus2IP_Mst_CmdAck));
    assign w_retry   = w_cmplt && w_fail && (32'(r_retry) < MAX_RETRY);
    assign w_col_end = (32'(r_col) == H_RES - 1);
    assign w_last    = w_col_end && (32'(r_line) == V_RES - 1);
    assign w_col_nx  = w_col_end ? '0 : r_col + COL_LEN'(1);
    assign w_line_nx = w_col_end ? r_line + LINE_LEN'(1) : r_line;
    assign w_back_nx = (32'(r_back) == NUM_BUFS - 1) ? 2'd0 : r_back + 2'd1;

    always_comb begin
        w_next           = r_state;
        fifo_rd_en       = (r_state == S_RD);
        IP2Bus_MstWr_Req = w_in_req;
        busy             = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: if (!fifo_empty) w_next = S_RD;
            S_RD:   w_next = S_DEC;
            S_DEC: begin
                case (w_op)
                    4'd0:       w_next = w_drop ? S_IDLE : S_PIX_REQ;
                    4'd1, 4'd2: w_next = S_CNTL_REQ;
                    default:    w_next = S_IDLE;
                endcase
            end
            S_PIX_REQ, S_CNTL_REQ, S_CLR_REQ: if (Bus2IP_Mst_CmdAck) w_next = S_WAIT;
            S_DONE: w_next = S_IDLE;
            default: ;
        endcase
        if (w_cmplt) begin
            if (w_retry) begin
                case (r_kind)
                    K_PIX:   w_next = S_PIX_REQ;
                    K_CNTL:  w_next = S_CNTL_REQ;
                    default: w_next = S_CLR_REQ;
                endcase
            end else if ((r_kind == K_CNTL && r_clr_pending) || (r_kind == K_CLR && !w_last)) begin
                w_next = S_CLR_REQ;
            end else begin
                w_next = S_DONE;
            end
        end
    end

    always_ff @(posedge PLB_clk or posedge Bus2IP_Reset) begin
        if (Bus2IP_Reset) begin
            r_state       <= S_IDLE;
            r_kind        <= K_PIX;
            r_addr        <= '0;
            r_data        <= '0;
            r_clr_col     <= '0;
            r_front       <= 2'd0;
            r_back        <= 2'd1;
            r_clr_pending <= 1'b0;
            r_clearing    <= 1'b0;
            r_err         <= 1'b0;
            r_line        <= '0;
            r_col         <= '0;
            r_retry       <= '0;
            r_drops       <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DEC) begin
                case (w_op)
                    4'd0: begin
                        if (w_drop) begin
                            if (r_drops != 16'hFFFF) r_drops <= r_drops + 16'd1;
                        end else begin
                            r_addr <= addr_of(r_back, w_line, w_col);
                            r_data <= w_colour;
                            r_kind <= K_PIX;
                        end
                    end
                    4'd1, 4'd2: begin
                        r_addr        <= FB_CNTL_ADDR;
                        r_data        <= addr_of(r_back, '0, '0);
                        r_kind        <= K_CNTL;
                        r_clr_pending <= (w_op == 4'd1);
                    end
                    4'd3:    r_clr_col <= w_colour;
                    default: ;
                endcase
            end
            if (w_cmplt) begin
                if (w_retry) begin
                    r_retry <= r_retry + 8'd1;
                end else begin
                    r_retry <= '0;
                    if (w_fail) r_err <= 1'b1;
                    // An abandoned control write still rotates, so the sweep targets the new back buffer.
                    if (r_kind == K_CNTL) begin
                        r_front <= r_back;
                        r_back  <= w_back_nx;
                        if (r_clr_pending) begin
                            r_clearing <= 1'b1;
                            r_line     <= '0;
                            r_col      <= '0;
                            r_addr     <= addr_of(w_back_nx, '0, '0);
                            r_data     <= r_clr_col;
                            r_kind     <= K_CLR;
                        end
                    end else if (r_kind == K_CLR) begin
                        if (w_last) begin
                            r_clearing <= 1'b0;
                        end else begin
                            r_line <= w_line_nx;
                            r_col  <= w_col_nx;
                            r_addr <= addr_of(r_back, w_line_nx, w_col_nx);
                        end
                    end
                end
            end
        end
    end

    assign IP2Bus_MstRd_Req = 1'b0;
    assign IP2Bus_Mst_BE    = 4'hF;
    assign IP2Bus_Mst_Lock  = 1'b0;
    assign IP2Bus_Mst_Reset = 1'b0;
    assign IP2Bus_Mst_Addr  = r_addr;
    assign IP2Bus_MstWr_d   = r_data;
    assign clearing         = r_clearing;
    assign front_buf        = r_front;
    assign err_flag         = r_err;
    assign drop_count       = r_drops;

endmodule
